// File: rtl/bit_selection_16x8_ctrl_if.sv
// Word-in / window-out stream bundle for the 16x8 selector controller.
// The master drives the upstream word and the downstream ready.
interface bit_selection_16x8_ctrl_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int COMMAND_WIDTH  = $clog2(DATA_WIDTH) - 1,
  parameter int OUT_DATA_WIDTH = DATA_WIDTH >> 1
);
  logic                      i_valid;
  logic                      o_ready;
  logic [DATA_WIDTH-1:0]     i_data_bus;
  logic [COMMAND_WIDTH-1:0]  i_start_cmd;
  logic [COMMAND_WIDTH-1:0]  i_stride;
  logic [COMMAND_WIDTH-1:0]  i_num_m1;
  logic                      o_valid;
  logic                      i_ready;
  logic [OUT_DATA_WIDTH-1:0] o_data_bus;
  logic [COMMAND_WIDTH-1:0]  o_cmd;
  logic                      o_last;

  modport master (
    output i_valid, i_data_bus, i_start_cmd,
    output i_stride, i_num_m1, i_ready,
    input  o_ready, o_valid, o_data_bus,
    input  o_cmd, o_last
  );

  modport slave (
    input  i_valid, i_data_bus, i_start_cmd,
    input  i_stride, i_num_m1, i_ready,
    output o_ready, o_valid, o_data_bus,
    output o_cmd, o_last
  );
endinterface

// File: rtl/bit_selection_16x8_ctrl.sv
// 16-to-8 window selector plus the controller that steps it
// through a per-word start/stride/count schedule.
module bit_selection_16x8_comb #(
  parameter int DATA_WIDTH     = 16,
  parameter int COMMAND_WIDTH  = $clog2(DATA_WIDTH) - 1,
  parameter int OUT_DATA_WIDTH = DATA_WIDTH >> 1
) (
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [COMMAND_WIDTH-1:0]  cmd,
  input  logic                      valid,
  input  logic                      en,
  output logic [OUT_DATA_WIDTH-1:0] sel
);
  localparam int IW = COMMAND_WIDTH + 1;

  logic [IW-1:0] base;

  // command k picks word[k+8:k+1]
  assign base = IW'(cmd) + IW'(1);

  always_comb begin
    sel = '0;
    if (valid && en)
      sel = data[base +: OUT_DATA_WIDTH];
  end
endmodule

module bit_selection_16x8_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int COMMAND_WIDTH  = $clog2(DATA_WIDTH) - 1,
  parameter int OUT_DATA_WIDTH = DATA_WIDTH >> 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  bit_selection_16x8_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic [COMMAND_WIDTH-1:0] cmd_q, cmd_d;
  logic [COMMAND_WIDTH-1:0] stride_q, stride_d;
  logic [COMMAND_WIDTH-1:0] cnt_q, cnt_d;
  logic                     ready, valid;
  logic                     last, accept, beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      cmd_q    <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cmd_q    <= cmd_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cmd_d    = cmd_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    valid    = 1'b0;
    last     = (state_q == RUN) &&
               (cnt_q == '0);
    unique case (state_q)
      IDLE: ready = i_en;
      RUN: begin
        valid = i_en;
        // reload only on the final beat
        ready = i_en & last & bus.i_ready;
      end
    endcase
    accept = bus.i_valid & ready;
    beat   = valid & bus.i_ready;
    if (beat) begin
      if (cnt_q != '0) begin
        cmd_d = cmd_q + stride_q;
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
    if (accept) begin
      word_d   = bus.i_data_bus;
      cmd_d    = bus.i_start_cmd;
      stride_d = bus.i_stride;
      cnt_d    = bus.i_num_m1;
      state_d  = RUN;
    end
  end

  assign bus.o_ready = ready & rst_n;
  assign bus.o_valid = valid;
  assign bus.o_cmd   = cmd_q;
  assign bus.o_last  = last;

  bit_selection_16x8_comb #(
    .DATA_WIDTH    (DATA_WIDTH),
    .COMMAND_WIDTH (COMMAND_WIDTH),
    .OUT_DATA_WIDTH(OUT_DATA_WIDTH)
  ) u_sel (
    .data (word_q),
    .cmd  (cmd_q),
    .valid(state_q == RUN),
    .en   (i_en),
    .sel  (bus.o_data_bus)
  );
endmodule

// File: tb/tb_bit_selection_16x8_ctrl.sv
// Directed bench for the 16x8 selector controller.
// Inputs change on negedge; outputs are checked 1ns later.
module tb_bit_selection_16x8_ctrl;
  logic clk;
  logic rst_n;
  logic i_en;

  int n_tests = 0;
  int n_fail  = 0;

  bit_selection_16x8_ctrl_if bus ();

  bit_selection_16x8_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .i_en (i_en),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seq1 [8] = '{8'h21, 8'h10, 8'h88, 8'h44,
                           8'h22, 8'h91, 8'h48, 8'hA4};
  logic [7:0] seq2 [4] = '{8'h48, 8'h10, 8'h22, 8'hA4};
  logic [2:0] cmd2 [4] = '{3'd6, 3'd1, 3'd4, 3'd7};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [15:0] w,
                       input logic [2:0] s,
                       input logic [2:0] st,
                       input logic [2:0] n);
    bus.i_valid     = 1'b1;
    bus.i_data_bus  = w;
    bus.i_start_cmd = s;
    bus.i_stride    = st;
    bus.i_num_m1    = n;
    #1 check("offer_ready", 32'(bus.o_ready), 1);
    @(negedge clk);
    bus.i_valid     = 1'b0;
    bus.i_data_bus  = 16'h5A5A;
    bus.i_start_cmd = 3'd5;
    bus.i_stride    = 3'd2;
    bus.i_num_m1    = 3'd6;
  endtask

  task automatic beat(input string tag,
                      input logic [7:0] d,
                      input logic [2:0] c,
                      input logic l);
    #1;
    check({tag, "_v"}, 32'(bus.o_valid), 1);
    check({tag, "_d"}, 32'(bus.o_data_bus), 32'(d));
    check({tag, "_c"}, 32'(bus.o_cmd), 32'(c));
    check({tag, "_l"}, 32'(bus.o_last), 32'(l));
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    #1;
    check({tag, "_v"}, 32'(bus.o_valid), 0);
    check({tag, "_r"}, 32'(bus.o_ready), 1);
    check({tag, "_l"}, 32'(bus.o_last), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    i_en            = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b1;
    bus.i_data_bus  = '0;
    bus.i_start_cmd = '0;
    bus.i_stride    = '0;
    bus.i_num_m1    = '0;
    #2;
    check("rst_v", 32'(bus.o_valid), 0);
    check("rst_r", 32'(bus.o_ready), 0);
    check("rst_d", 32'(bus.o_data_bus), 0);
    check("rst_c", 32'(bus.o_cmd), 0);
    check("rst_l", 32'(bus.o_last), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk("post_rst");

    offer(16'hA442, 3'd0, 3'd1, 3'd7);
    for (int k = 0; k < 8; k++)
      beat("t1", seq1[k], 3'(k), k == 7);
    idle_chk("t1_idle");

    offer(16'hA442, 3'd6, 3'd3, 3'd3);
    for (int k = 0; k < 4; k++)
      beat("t2", seq2[k], cmd2[k], k == 3);
    idle_chk("t2_idle");

    offer(16'hA442, 3'd0, 3'd1, 3'd7);
    beat("t3", seq1[0], 3'd0, 1'b0);
    beat("t3", seq1[1], 3'd1, 1'b0);
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_stall_v", 32'(bus.o_valid), 1);
      check("t3_stall_d", 32'(bus.o_data_bus), 32'h88);
      check("t3_stall_c", 32'(bus.o_cmd), 2);
      check("t3_stall_l", 32'(bus.o_last), 0);
      check("t3_stall_r", 32'(bus.o_ready), 0);
      @(negedge clk);
    end
    bus.i_ready = 1'b1;
    for (int k = 2; k < 8; k++)
      beat("t3", seq1[k], 3'(k), k == 7);
    idle_chk("t3_idle");

    offer(16'hA442, 3'd0, 3'd1, 3'd7);
    for (int k = 0; k < 7; k++)
      beat("t4", seq1[k], 3'(k), 1'b0);
    bus.i_valid     = 1'b1;
    bus.i_data_bus  = 16'h00FF;
    bus.i_start_cmd = 3'd7;
    bus.i_stride    = 3'd0;
    bus.i_num_m1    = 3'd1;
    #1;
    check("t4_last_d", 32'(bus.o_data_bus), 32'hA4);
    check("t4_last_l", 32'(bus.o_last), 1);
    check("t4_b2b_r", 32'(bus.o_ready), 1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    beat("t4_w2a", 8'h00, 3'd7, 1'b0);
    beat("t4_w2b", 8'h00, 3'd7, 1'b1);
    idle_chk("t4_idle");

    offer(16'hA442, 3'd0, 3'd1, 3'd7);
    beat("t5", seq1[0], 3'd0, 1'b0);
    beat("t5", seq1[1], 3'd1, 1'b0);
    i_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t5_en_v", 32'(bus.o_valid), 0);
      check("t5_en_r", 32'(bus.o_ready), 0);
      @(negedge clk);
    end
    i_en = 1'b1;
    for (int k = 2; k < 8; k++)
      beat("t5", seq1[k], 3'(k), k == 7);
    idle_chk("t5_idle");

    offer(16'hA442, 3'd0, 3'd1, 3'd7);
    beat("t6", seq1[0], 3'd0, 1'b0);
    beat("t6", seq1[1], 3'd1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_v", 32'(bus.o_valid), 0);
    check("t6_rst_r", 32'(bus.o_ready), 0);
    check("t6_rst_d", 32'(bus.o_data_bus), 0);
    check("t6_rst_c", 32'(bus.o_cmd), 0);
    check("t6_rst_l", 32'(bus.o_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk("t6_post");
    offer(16'hA442, 3'd6, 3'd3, 3'd3);
    for (int k = 0; k < 4; k++)
      beat("t6w", seq2[k], cmd2[k], k == 3);
    idle_chk("t6_idle");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_selection_16x8_ctrl.md
# bit_selection_16x8_ctrl

Sequencing controller for the 16-to-8 combinational bit selector. It accepts one 16-bit word per valid/ready handshake together with a window schedule (start command, stride, window count). It then steps the selector command through that schedule, emitting one 8-bit window per beat on a backpressured output stream. It contains one `bit_selection_16x8_comb` instance, which it drives from registered state, and sits between a word source (e.g. a buffer read port) and an 8-bit NoC/PE consumer.

## Interface
Parameters:
- `DATA_WIDTH`, 16: input word width; only 16 is supported.
- `COMMAND_WIDTH`, 3: selector command width, `$clog2(DATA_WIDTH)-1`.
- `OUT_DATA_WIDTH`, 8: output width, `DATA_WIDTH>>1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_en`  in  1  global enable; low freezes the block.
- `i_valid`  in  1  upstream word valid.
- `o_ready`  out  1  upstream ready.
- `i_data_bus`  in  16  word to slice.
- `i_start_cmd`  in  3  first selector command.
- `i_stride`  in  3  command increment per beat.
- `i_num_m1`  in  3  number of windows minus one (1..8 windows).
- `o_valid`  out  1  output window valid.
- `i_ready`  in  1  downstream ready.
- `o_data_bus`  out  8  selected window.
- `o_cmd`  out  3  command that produced `o_data_bus`.
- `o_last`  out  1  high on the final window of the current word.

## Operation
- Selector semantics: command k yields `word[k+8:k+1]`. Command 0 yields `[8:1]`; command 7 yields `[15:8]`.
- Registers: `word_q[15:0]`, `cmd_q[2:0]`, `stride_q[2:0]`, `cnt_q[2:0]`, `state_q`.
- The selector instance is fed `word_q`, `cmd_q`, valid = (state==RUN), en = `i_en`.
- `o_data_bus` is the selector output.
- `o_cmd` = `cmd_q`; `o_last` = RUN & (`cnt_q`==0).
- FSM states:
  - IDLE:
    - `o_ready` = `i_en`; `o_valid` = 0.
    - Accept (`i_valid & o_ready`): load `word_q`, `cmd_q`←`i_start_cmd`, `stride_q`, `cnt_q`←`i_num_m1`; go to RUN.
  - RUN:
    - `o_valid` = `i_en`.
    - Beat = `o_valid & i_ready`.
    - On a beat with `cnt_q`≠0: `cmd_q`←`cmd_q`+`stride_q` (mod 8, 3-bit wrap); `cnt_q`←`cnt_q`−1.
    - On a beat with `cnt_q`==0: word done.
- Back-to-back: in RUN, `o_ready` = `i_en & o_last & i_ready`.
  - If a new word is accepted on the last beat, the registers reload and the state stays RUN (no bubble).
  - Otherwise the last beat returns the FSM to IDLE.
- Stride 0 is legal: the same window repeats `i_num_m1`+1 times.
- Command wrap is pure modulo-8. Example: start 6, stride 3 gives 6,1,4,7.
- `i_en` low:
  - `o_valid`=0 and `o_ready`=0.
  - No register changes; outputs resume unchanged when `i_en` returns high.
- Stall (`o_valid & !i_ready`): `o_data_bus`, `o_cmd` and `o_last` hold stable; nothing advances.
- Upstream inputs are sampled only on the accept edge. They may change freely otherwise.

## Timing
- Reset (`rst_n` low, asynchronous, any state, including mid-word):
  - State←IDLE; `word_q`, `cmd_q`, `stride_q`, `cnt_q`←0.
  - Outputs: `o_valid`=0, `o_ready`=0 while `rst_n` low (then `i_en`), `o_data_bus`=0x00, `o_cmd`=0, `o_last`=0.
  - Any in-flight word is discarded.
- Latency: a word accepted at edge N has its first window valid in the cycle after edge N.
- `o_data_bus` path: registers → combinational selector → port (no extra register).
- Throughput: one window per cycle while `i_ready`=1. A word of n windows occupies exactly n cycles; the next word's first window follows the last window with no gap.
- `o_valid` never drops during a word except via `i_en` low. `o_last` coincides with exactly one beat per word.

## Test plan
- Word 0xA442, start 0, stride 1, num_m1 7, `i_ready`=1 → 8 consecutive windows 21,10,88,44,22,91,48,A4. Cmds 0..7; `o_last` only on A4; then IDLE, `o_ready`=1.
- Word 0xA442, start 6, stride 3, num_m1 3 → cmds 6,1,4,7, data 48,10,22,A4 (wrap check).
- Backpressure: same as the first test, with `i_ready` low for 3 cycles on the 0x88 beat → 0x88/cmd 2 held 4 cycles; no window lost or duplicated.
- Back-to-back: second word 0x00FF (start 7, stride 0, num_m1 1) offered during the first word's last beat → accepted on that edge; next cycles output 00,00 with no idle cycle between A4 and the first 00.
- `i_en` dropped for 2 cycles mid-word (after 0x10) → `o_valid`=0 and `o_ready`=0 during those cycles; resumes with 0x88.
- Assert `rst_n` low asynchronously mid-word (between edges) → outputs go to reset values immediately; after release, the next accepted word starts at its own start command.
